// File: rtl/qpsk_pkg.sv
// qpsk_pkg
// Shared constants and helpers for the QPSK symbol sequencer: the 16-entry
// modulation sample table, the symbol-to-phase Gray mapping, the FSM state
// encoding and the idle (midscale) output level.
package qpsk_pkg;

  localparam int DATA_W     = 8;
  localparam int TBL_AW     = 4;
  localparam int TBL_DEPTH  = 2 ** TBL_AW;
  localparam int PHASE_STEP = 4;

  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(100);

  // One full period of the carrier; every symbol reads the same table,
  // only the starting phase differs.
  localparam logic [DATA_W-1:0] SIN_TBL [TBL_DEPTH] = '{
    8'd100, 8'd127, 8'd150, 8'd165, 8'd171, 8'd165, 8'd150, 8'd127,
    8'd100, 8'd73,  8'd50,  8'd35,  8'd29,  8'd35,  8'd50,  8'd73
  };

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Gray mapping 00->0, 01->1, 11->2, 10->3 quadrants. The rank is the
  // binary value of the Gray code, so adjacent phases differ by one bit.
  function automatic logic [TBL_AW-1:0] sym_offset(input logic [1:0] sym);
    logic [TBL_AW-1:0] rank;
    rank = TBL_AW'({sym[1], sym[1] ^ sym[0]});
    return rank * TBL_AW'(PHASE_STEP);
  endfunction

endpackage

// File: rtl/qpsk_sym_hold.sv
// qpsk_sym_hold
// One-entry holding register between the symbol source and the sequencer.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   sym_in      - incoming 2-bit symbol
//   sym_valid   - sym_in is valid
//   sym_ready   - buffer is empty and not in reset
//   pop         - sequencer consumes the held symbol at this edge
//   hold_sym    - held symbol
//   hold_valid  - hold_sym is occupied
module qpsk_sym_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       pop,
  output logic [1:0] hold_sym,
  output logic       hold_valid
);

  logic accept;

  assign sym_ready = !hold_valid && !rst;
  assign accept    = sym_valid && sym_ready;

  // Accept only into an empty buffer, so accept and pop are never in the
  // same cycle and a simple priority chain is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_sym   <= 2'b00;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_sym   <= sym_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qpsk_sym_sequencer.sv
// qpsk_sym_sequencer
// Plays each accepted QPSK symbol as 16 consecutive samples of the shared
// sine table, starting at a symbol-dependent phase offset. Symbols queued in
// the one-deep hold buffer follow back to back with no gap; when nothing is
// pending the output parks at midscale.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   sym_in        - symbol to transmit
//   sym_valid     - sym_in is valid
//   sym_ready     - a symbol can be accepted this cycle
//   sample_out    - registered DAC sample
//   sample_valid  - sample_out carries a symbol sample
//   sym_start     - pulse with sample 0 of every symbol
//   underrun      - pulse when the stream drains to idle
module qpsk_sym_sequencer
  import qpsk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              sym_start,
  output logic              underrun
);

  state_t            state;
  logic [TBL_AW-1:0] idx;
  logic [TBL_AW-1:0] cur_off;
  logic [1:0]        hold_sym;
  logic              hold_valid;
  logic              pop;
  logic [TBL_AW-1:0] pop_off;
  logic [TBL_AW-1:0] run_addr;

  qpsk_sym_hold u_hold (
    .clk        (clk),
    .rst        (rst),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .pop        (pop),
    .hold_sym   (hold_sym),
    .hold_valid (hold_valid)
  );

  // A symbol is taken from the buffer when idle, or when the running symbol
  // has just presented its last sample (idx wrapped to 0). Table addresses
  // wrap mod 16 by plain 4-bit addition.
  always_comb begin
    pop      = hold_valid && ((state == IDLE) || (idx == '0));
    pop_off  = sym_offset(hold_sym);
    run_addr = idx + cur_off;
  end

  // Sample 0 of a new symbol is emitted on the pop edge itself, which keeps
  // consecutive symbols contiguous; idx then counts 1..15 and wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cur_off      <= '0;
      sample_out   <= MIDSCALE;
      sample_valid <= 1'b0;
      sym_start    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sym_start <= 1'b0;
      underrun  <= 1'b0;
      if (pop) begin
        state        <= RUN;
        cur_off      <= pop_off;
        idx          <= TBL_AW'(1);
        sample_out   <= SIN_TBL[pop_off];
        sample_valid <= 1'b1;
        sym_start    <= 1'b1;
      end else if (state == RUN) begin
        if (idx != '0) begin
          sample_out <= SIN_TBL[run_addr];
          idx        <= idx + TBL_AW'(1);
        end else begin
          state        <= IDLE;
          sample_out   <= MIDSCALE;
          sample_valid <= 1'b0;
          underrun     <= 1'b1;
        end
      end else begin
        sample_out   <= MIDSCALE;
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_sym_sequencer.sv
// tb_qpsk_sym_sequencer
// Scoreboard bench: every accepted symbol expands into its 16 expected
// samples in a queue; a monitor on the falling edge pops and compares
// whenever the sequencer presents a sample, and checks idle level, pulse
// behaviour and gap-free playback.
module tb_qpsk_sym_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sym_start;
  logic       underrun;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    int value;
    bit first;
  } exp_t;

  exp_t q[$];

  bit rstAtEdge   = 1'b1;
  bit acceptedNow = 1'b0;
  bit prevValid   = 1'b0;
  int stall       = 0;

  qpsk_sym_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sym_start    (sym_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: one carrier period, entered at quadrant rank*90deg
  // where rank follows the Gray order 00,01,11,10.
  function automatic void pushSymbol(input logic [1:0] s);
    int tbl[16] = '{100, 127, 150, 165, 171, 165, 150, 127,
                    100, 73, 50, 35, 29, 35, 50, 73};
    int rank[4] = '{0, 1, 3, 2};
    int phase;
    exp_t e;
    phase = rank[s] * 4;
    for (int j = 0; j < 16; j++) begin
      e.value = tbl[(phase + j) % 16];
      e.first = (j == 0);
      q.push_back(e);
    end
  endfunction

  // Handshake observer: records accepted symbols into the scoreboard and
  // drops everything still expected when reset is taken.
  always @(posedge clk) begin
    rstAtEdge <= rst;
    if (rst) begin
      q.delete();
      acceptedNow <= 1'b0;
    end else if (sym_valid && sym_ready) begin
      pushSymbol(sym_in);
      acceptedNow <= 1'b1;
    end else begin
      acceptedNow <= 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rstAtEdge) begin
      checkOutput("rst_sample_out", int'(sample_out), 100);
      checkOutput("rst_sample_valid", int'(sample_valid), 0);
      checkOutput("rst_sym_start", int'(sym_start), 0);
      checkOutput("rst_underrun", int'(underrun), 0);
      if (rst) checkOutput("rst_sym_ready", int'(sym_ready), 0);
      prevValid = 1'b0;
      stall = 0;
    end else begin
      if (sample_valid) begin
        stall = 0;
        checkOutput("underrun_while_valid", int'(underrun), 0);
        if (q.size() == 0) begin
          checkOutput("unexpected_sample", 1, 0);
        end else begin
          e = q.pop_front();
          checkOutput("sample_value", int'(sample_out), e.value);
          checkOutput("sym_start", int'(sym_start), int'(e.first));
        end
      end else begin
        checkOutput("idle_level", int'(sample_out), 100);
        checkOutput("idle_sym_start", int'(sym_start), 0);
        if (prevValid) begin
          checkOutput("underrun_pulse", int'(underrun), 1);
          checkOutput("gap_in_stream", int'((q.size() == 0) || (acceptedNow && q.size() == 16)), 1);
        end else begin
          checkOutput("spurious_underrun", int'(underrun), 0);
        end
        if (q.size() != 0) begin
          stall++;
          if (stall > 1) checkOutput("start_latency", stall, 1);
        end
      end
      prevValid = sample_valid;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a symbol and keeps sym_valid high until it is accepted;
  // sym_valid is left asserted so callers can chain symbols.
  task automatic applyStimulus(input logic [1:0] s);
    bit ok = 1'b0;
    int n = 0;
    sym_in = s;
    sym_valid = 1'b1;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = sym_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  initial begin
    int n;
    $display("[TB] start");

    rst = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);

    // Single symbols, each allowed to drain to idle.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(2'(s));
      sym_valid = 1'b0;
      waitCycles(22);
    end

    // 11 arrives mid-symbol behind 00: playback must be contiguous.
    applyStimulus(2'b00);
    sym_valid = 1'b0;
    waitCycles(5);
    applyStimulus(2'b11);
    sym_valid = 1'b0;
    waitCycles(40);

    // Backpressure with sym_valid held across three symbols.
    applyStimulus(2'b00);
    checkOutput("bp_ready_low_after_accept", int'(sym_ready), 0);
    applyStimulus(2'b01);
    waitCycles(3);
    checkOutput("bp_one_symbol_held", int'(sym_ready), 0);
    applyStimulus(2'b11);
    sym_valid = 1'b0;
    waitCycles(60);

    // Reset on sample 7 of 01 with 10 held; 10 must never play.
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    sym_valid = 1'b0;
    waitCycles(6);
    rst = 1'b1;
    checkOutput("rst_ready_comb", int'(sym_ready), 0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(30);
    checkOutput("held_discarded", int'(sample_valid), 0);

    // Long idle.
    waitCycles(50);

    // Random symbols with random gaps.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(2'($urandom_range(0, 3)));
      sym_valid = 1'b0;
      waitCycles($urandom_range(0, 20));
    end

    n = 0;
    while ((q.size() != 0 || sample_valid) && n < 200) begin
      waitCycles(1);
      n++;
    end
    checkOutput("drain_queue_empty", q.size(), 0);
    checkOutput("drain_idle", int'(sample_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/qpsk_sym_sequencer.md
Name: qpsk_sym_sequencer

Overview:
Sequences the shared 16-entry modulation sample table so that one table serves all four QPSK symbols, replacing one free-running LUT block per symbol.
- Accepts 2-bit symbols over a valid/ready handshake.
- Each symbol is buffered one deep and played as 16 consecutive table samples, starting at a symbol-dependent phase offset.
- Output feeds the DAC sample path. When no symbol is pending, the output parks at midscale.

Parameters:
- DATA_W, 8, sample width.
- TBL_AW, 4, table address width; table depth is 2**TBL_AW = 16 samples per symbol.
- PHASE_STEP, 4, table entries per 90° of phase.
- MIDSCALE, 100, idle/reset output level.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sym_in  in  2  symbol to transmit.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  block can accept a symbol this cycle.
- sample_out  out  DATA_W  registered sample.
- sample_valid  out  1  sample_out carries a symbol sample.
- sym_start  out  1  one-cycle pulse, high with sample 0 of each symbol.
- underrun  out  1  one-cycle pulse when the stream drains to idle.

Behaviour:
- Reset: one clock, single interface — clk plus synchronous active-high rst.
  - Outputs go to sample_out=MIDSCALE, sample_valid=0, sym_start=0, underrun=0.
  - Internal state goes to state=IDLE, hold_valid=0, idx=0.
  - sym_ready=0 while rst is high.
- Reset mid-symbol: the current symbol and the held symbol are discarded, and reset values appear after that edge.
- Hold buffer (one entry):
  - sym_ready = !hold_valid && !rst.
  - Accept on sym_valid && sym_ready. hold_sym<=sym_in and hold_valid<=1 at that edge.
  - Accept and pop never coincide, because accept requires an empty buffer.
- Phase offset (Gray mapping): 00→0, 01→4, 11→8, 10→12, i.e. k*PHASE_STEP.
- Table address = (idx + offset) mod 16, using 4-bit wrap with the carry discarded.
- State machine IDLE / RUN:
  - IDLE, hold_valid=1 → pop at the edge: cur_off<=offset(hold_sym), hold_valid<=0, state<=RUN, idx<=1, sample_out<=table[offset], sample_valid<=1, sym_start<=1.
  - IDLE, hold_valid=0 → stay in IDLE; sample_out=MIDSCALE, sample_valid=0.
  - RUN, idx≠0 → sample_out<=table[idx+cur_off], idx<=idx+1 (wraps 15→0), sym_start<=0.
  - RUN, idx=0 (all 16 samples presented) and hold_valid=1 → pop the next symbol exactly as from IDLE. Output is contiguous with no gap cycle.
  - RUN, idx=0 and hold_valid=0 → state<=IDLE, sample_out<=MIDSCALE, sample_valid<=0, underrun<=1 for one cycle.
- Latency: a symbol accepted at edge N into an idle block gives sample 0 visible after edge N+1.
- Throughput: one symbol per 16 cycles, sustained. sym_ready reasserts the cycle after a pop.
- Arithmetic: table entries are unsigned DATA_W. No arithmetic is done on samples; only index addition mod 16.

Decomposition:
- Shared package qpsk_pkg holds:
  - the 16-entry table constant SIN_TBL = {100,127,150,165,171,165,150,127,100,73,50,35,29,35,50,73};
  - the symbol-to-offset Gray mapping function;
  - the state enum {IDLE, RUN};
  - MIDSCALE.
- One natural sub-module: qpsk_sym_hold (one-entry valid/ready holding register).
- Table read, index counter and FSM stay in the top module.

Test Plan:
- Reset, then sym 00 accepted at edge N → from edge N+1: 100,127,150,165,171,165,150,127,100,73,50,35,29,35,50,73. sym_start high on the first sample only; then sample_out=100, sample_valid=0, underrun pulse.
- Sym 01 → 171,165,150,127,100,73,50,35,29,35,50,73,100,127,150,165. Sym 10 → first four samples 29,35,50,73.
- Back-to-back 00 then 11, second accepted mid-symbol:
  - last 00 sample 73 is followed immediately by 100,73,50,…;
  - sym_start pulses on that 100;
  - no underrun, sample_valid stays continuously 1 for 32 cycles.
- Backpressure: sym_valid held high with 00,01,11 presented on consecutive cycles:
  - sym_ready goes low after the first accept;
  - exactly one symbol waits in the hold buffer;
  - no symbol is lost or duplicated, and the played order is 00,01,11.
- Reset asserted on sample 7 of sym 01 with a symbol held → after that edge: sample_out=100, sample_valid=0, sym_ready=0 while rst=1. The held symbol is never played.
- Idle with sym_valid=0 for 50 cycles → sample_out stays at 100, no sym_start, no underrun pulses.
